ser_mem_bridge: RTL and testbench

Serial/parallel peripheral bridge that replaces the fixed 8-bit loader and 32-bit P2S in the peripheral datapath. The load path assembles a serial bitstream into DATA_W-bit words and writes them to instruction SRAM with an auto-incrementing address, and reports done and overflow. The unload path captures an OUT_W-bit result, such as the ALU output, and shifts it out serially with a valid strobe. Word width, memory depth and result width are parameters.

---
 rtl/ser_mem_bridge_if.sv | 34 +++
 rtl/ser_mem_bridge.sv | 158 +++++++++++++++
 tb/tb_ser_mem_bridge.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ser_mem_bridge_if.sv
// Handshake/bus bundle for ser_mem_bridge: serial load inputs, SRAM write
// port, and the parallel-to-serial unload channel.
interface ser_mem_bridge_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 32
);
  logic              ld_en;
  logic              ld_bit;
  logic              ld_clr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              ld_done;
  logic              ld_ovf;
  logic              p2s_load;
  logic [OUT_W-1:0]  p2s_din;
  logic              p2s_enable;
  logic              p2s_ser_out;
  logic              p2s_valid;
  logic              p2s_busy;

  modport master (
    output ld_en, ld_bit, ld_clr, p2s_load, p2s_din, p2s_enable,
    input  mem_we, mem_addr, mem_wdata, ld_done, ld_ovf,
           p2s_ser_out, p2s_valid, p2s_busy
  );

  modport slave (
    input  ld_en, ld_bit, ld_clr, p2s_load, p2s_din, p2s_enable,
    output mem_we, mem_addr, mem_wdata, ld_done, ld_ovf,
           p2s_ser_out, p2s_valid, p2s_busy
  );
endinterface

// File: rtl/ser_mem_bridge.sv
// Serial loader into instruction SRAM plus parallel-to-serial result unloader.
// Define SER_MSB_FIRST_EN for MSB-first bit order in both paths (default LSB-first).
//
// Unload FSM:
//   state     | meaning
//   P2S_IDLE  | waiting for p2s_load; outputs quiet
//   P2S_SHIFT | presenting head bit, advancing on p2s_enable
module ser_mem_bridge #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int OUT_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ser_mem_bridge_if.slave bus
);

`ifdef SER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  localparam int LBW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int UBW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [LBW-1:0]    LD_LAST   = LBW'(DATA_W - 1);
  localparam logic [UBW-1:0]    P2S_LAST  = UBW'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {P2S_IDLE, P2S_SHIFT} p2s_state_e;

  logic [LBW-1:0]    ld_cnt_q, ld_cnt_d;
  logic [DATA_W-1:0] ld_sh_q, ld_sh_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_cur;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  p2s_state_e        state_q, state_d;
  logic [OUT_W-1:0]  p2s_sh_q, p2s_sh_d;
  logic [UBW-1:0]    p2s_cnt_q, p2s_cnt_d;
  logic              ser_out, valid, busy;

  always_comb begin
    ld_cnt_d = ld_cnt_q;
    ld_sh_d  = ld_sh_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    // Address of the word being assembled: a write in flight has already claimed addr_q.
    addr_cur = addr_q;
    if (we_q && (addr_q != ADDR_LAST)) begin
      addr_cur = addr_q + 1'b1;
    end
    if (bus.ld_clr) begin
      ld_cnt_d = '0;
      ld_sh_d  = '0;
      addr_d   = '0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      addr_d = addr_cur;
      if (bus.ld_en && done_q) begin
        ovf_d = 1'b1;
      end else if (bus.ld_en) begin
        if (MSB_FIRST) begin
          ld_sh_d    = ld_sh_q << 1;
          ld_sh_d[0] = bus.ld_bit;
        end else begin
          ld_sh_d             = ld_sh_q >> 1;
          ld_sh_d[DATA_W-1]   = bus.ld_bit;
        end
        if (ld_cnt_q == LD_LAST) begin
          ld_cnt_d = '0;
          wdata_d  = ld_sh_d;
          we_d     = 1'b1;
          if (addr_cur == ADDR_LAST) begin
            done_d = 1'b1;
          end
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    p2s_sh_d  = p2s_sh_q;
    p2s_cnt_d = p2s_cnt_q;
    ser_out   = 1'b0;
    valid     = 1'b0;
    busy      = 1'b0;
    case (state_q)
      P2S_IDLE: begin
        if (bus.p2s_load) begin
          p2s_sh_d  = bus.p2s_din;
          p2s_cnt_d = '0;
          state_d   = P2S_SHIFT;
        end
      end
      P2S_SHIFT: begin
        busy    = 1'b1;
        valid   = bus.p2s_enable;
        ser_out = MSB_FIRST ? p2s_sh_q[OUT_W-1] : p2s_sh_q[0];
        if (bus.p2s_enable) begin
          p2s_sh_d = MSB_FIRST ? (p2s_sh_q << 1) : (p2s_sh_q >> 1);
          if (p2s_cnt_q == P2S_LAST) begin
            state_d = P2S_IDLE;
          end else begin
            p2s_cnt_d = p2s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = P2S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt_q  <= '0;
      ld_sh_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      state_q   <= P2S_IDLE;
      p2s_sh_q  <= '0;
      p2s_cnt_q <= '0;
    end else begin
      ld_cnt_q  <= ld_cnt_d;
      ld_sh_q   <= ld_sh_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      p2s_sh_q  <= p2s_sh_d;
      p2s_cnt_q <= p2s_cnt_d;
    end
  end

  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.ld_done     = done_q;
  assign bus.ld_ovf      = ovf_q;
  assign bus.p2s_ser_out = ser_out;
  assign bus.p2s_valid   = valid;
  assign bus.p2s_busy    = busy;

endmodule

// File: tb/tb_ser_mem_bridge.sv
// Bench for ser_mem_bridge: directed and random stimulus against a word/queue level
// reference model, checked every cycle on the falling edge.
module tb_ser_mem_bridge;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int OUT_W  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ser_mem_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

  ser_mem_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // load model: words completed so far, bits of the current word, flags
  int                m_nbits, m_words;
  bit                m_done, m_ovf, m_we;
  logic [DATA_W-1:0] m_acc, m_wdata;
  int                m_wr_addr;
  // unload model: bits still to emit, in emission order
  bit                m_q[$];
  bit                m_busy;
  logic [OUT_W-1:0]  rx_word;
  int                rx_cnt;

  function automatic logic [ADDR_W-1:0] exp_addr();
    if (m_we) return ADDR_W'(m_wr_addr);
    return ADDR_W'((m_words > DEPTH - 1) ? DEPTH - 1 : m_words);
  endfunction

  task automatic model_reset();
    m_nbits = 0; m_words = 0; m_done = 0; m_ovf = 0; m_we = 0;
    m_acc = '0; m_wdata = '0; m_wr_addr = 0;
    m_q.delete(); m_busy = 0;
  endtask

  task automatic model_step();
    if (bus.ld_clr) begin
      m_nbits = 0; m_words = 0; m_done = 0; m_ovf = 0; m_we = 0;
    end else begin
      m_we = 0;
      if (bus.ld_en) begin
        if (m_done) m_ovf = 1;
        else begin
`ifdef SER_MSB_FIRST_EN
          m_acc[DATA_W-1-m_nbits] = bus.ld_bit;
`else
          m_acc[m_nbits] = bus.ld_bit;
`endif
          m_nbits++;
          if (m_nbits == DATA_W) begin
            m_we = 1; m_wdata = m_acc; m_wr_addr = m_words;
            m_words++; m_nbits = 0;
            if (m_words == DEPTH) m_done = 1;
          end
        end
      end
    end
    if (!m_busy) begin
      if (bus.p2s_load) begin
        for (int i = 0; i < OUT_W; i++) begin
`ifdef SER_MSB_FIRST_EN
          m_q.push_back(bus.p2s_din[OUT_W-1-i]);
`else
          m_q.push_back(bus.p2s_din[i]);
`endif
        end
        m_busy = 1;
      end
    end else if (bus.p2s_enable) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_busy = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("mem_we",      bus.mem_we,      m_we);
    check("mem_addr",    bus.mem_addr,    exp_addr());
    check("mem_wdata",   bus.mem_wdata,   m_wdata);
    check("ld_done",     bus.ld_done,     m_done);
    check("ld_ovf",      bus.ld_ovf,      m_ovf);
    check("p2s_busy",    bus.p2s_busy,    m_busy);
    check("p2s_valid",   bus.p2s_valid,   m_busy && bus.p2s_enable);
    check("p2s_ser_out", bus.p2s_ser_out, m_busy ? m_q[0] : 1'b0);
    if (bus.p2s_valid) begin
`ifdef SER_MSB_FIRST_EN
      rx_word = {rx_word[OUT_W-2:0], bus.p2s_ser_out};
`else
      if (rx_cnt < OUT_W) rx_word[rx_cnt] = bus.p2s_ser_out;
`endif
      rx_cnt++;
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input bit gap);
    for (int i = 0; i < DATA_W; i++) begin
      bus.ld_en = 1'b1;
`ifdef SER_MSB_FIRST_EN
      bus.ld_bit = w[DATA_W-1-i];
`else
      bus.ld_bit = w[i];
`endif
      tick();
      if (gap && i != DATA_W - 1) begin
        bus.ld_en  = 1'b0;
        bus.ld_bit = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus.ld_en = 1'b0;
  endtask

  task automatic clear_load();
    bus.ld_clr = 1'b1;
    tick();
    bus.ld_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OUT_W-1:0] din_saved;
    bus.ld_en = 1'b0; bus.ld_bit = 1'b0; bus.ld_clr = 1'b0;
    bus.p2s_load = 1'b0; bus.p2s_din = '0; bus.p2s_enable = 1'b0;
    model_reset();
    rx_word = '0; rx_cnt = 0;

    #3;
    check("rst_mem_we",   bus.mem_we,      1'b0);
    check("rst_mem_addr", bus.mem_addr,    '0);
    check("rst_wdata",    bus.mem_wdata,   '0);
    check("rst_done",     bus.ld_done,     1'b0);
    check("rst_ovf",      bus.ld_ovf,      1'b0);
    check("rst_busy",     bus.p2s_busy,    1'b0);
    check("rst_valid",    bus.p2s_valid,   1'b0);
    check("rst_ser_out",  bus.p2s_ser_out, 1'b0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // single word, ld_en held
    send_word(8'h93, 1'b0);
    check("w93_we",   bus.mem_we,    1'b1);
    check("w93_data", bus.mem_wdata, 8'h93);
    check("w93_addr", bus.mem_addr,  10'd0);
    tick();
    check("w93_we_off",   bus.mem_we,   1'b0);
    check("w93_addr_inc", bus.mem_addr, 10'd1);

    // gapped stream
    clear_load();
    send_word(8'h5A, 1'b1);
    check("w5a_data", bus.mem_wdata, 8'h5A);
    check("w5a_addr", bus.mem_addr,  10'd0);
    tick();

    // clear mid-word, then clear together with the last bit
    for (int i = 0; i < 5; i++) begin
      bus.ld_en = 1'b1; bus.ld_bit = 1'($urandom_range(0, 1)); tick();
    end
    bus.ld_clr = 1'b1; tick(); bus.ld_clr = 1'b0; bus.ld_en = 1'b0;
    tick();
    check("clr_addr", bus.mem_addr, 10'd0);
    check("clr_done", bus.ld_done,  1'b0);
    for (int i = 0; i < 7; i++) begin
      bus.ld_en = 1'b1; bus.ld_bit = 1'($urandom_range(0, 1)); tick();
    end
    bus.ld_clr = 1'b1; bus.ld_bit = 1'b1; tick();
    bus.ld_clr = 1'b0; bus.ld_en = 1'b0;
    check("clr_last_we", bus.mem_we, 1'b0);
    send_word(8'hC3, 1'b0);
    check("after_clr_data", bus.mem_wdata, 8'hC3);
    check("after_clr_addr", bus.mem_addr,  10'd0);
    tick();

    // full load, back-to-back, then overflow
    clear_load();
    for (int w = 1; w <= DEPTH; w++) send_word(DATA_W'(w), 1'b0);
    check("full_done", bus.ld_done,  1'b1);
    check("full_addr", bus.mem_addr, 10'(DEPTH - 1));
    check("full_data", bus.mem_wdata, 8'h04);
    tick();
    bus.ld_en = 1'b1; bus.ld_bit = 1'b1; tick();
    bus.ld_en = 1'b0;
    check("ovf_set", bus.ld_ovf, 1'b1);
    for (int i = 0; i < DATA_W + 2; i++) begin
      bus.ld_en = 1'($urandom_range(0, 1)); tick();
    end
    bus.ld_en = 1'b0;

    // random load rounds with occasional clears
    for (int r = 0; r < 4; r++) begin
      clear_load();
      for (int c = 0; c < 600 && !m_done; c++) begin
        bus.ld_en  = ($urandom_range(0, 2) != 0);
        bus.ld_bit = 1'($urandom_range(0, 1));
        bus.ld_clr = ($urandom_range(0, 63) == 0);
        tick();
      end
      bus.ld_clr = 1'b0;
      check("rand_load_done", bus.ld_done, 1'b1);
      for (int c = 0; c < 6; c++) begin
        bus.ld_en = 1'($urandom_range(0, 1)); bus.ld_bit = 1'($urandom_range(0, 1)); tick();
      end
      bus.ld_en = 1'b0;
    end

    // unload 0xDEADBEEF with alternating enable; loads mid-shift and at the end are ignored
    bus.p2s_din = 32'hDEADBEEF; bus.p2s_load = 1'b1; bus.p2s_enable = 1'b0;
    tick();
    rx_word = '0; rx_cnt = 0;
    for (int i = 0; i < 200 && m_busy; i++) begin
      bus.p2s_enable = (i % 2 == 0);
      bus.p2s_load   = (i == 20) || (m_q.size() == 1);
      bus.p2s_din    = 32'h12345678;
      tick();
    end
    bus.p2s_load = 1'b0; bus.p2s_enable = 1'b0;
    check("p2s_word",     rx_word,      32'hDEADBEEF);
    check("p2s_nbits",    rx_cnt,       OUT_W);
    check("p2s_busy_end", bus.p2s_busy, 1'b0);
    tick();

    // random unloads
    for (int r = 0; r < 6; r++) begin
      din_saved = $urandom;
      bus.p2s_din = din_saved; bus.p2s_load = 1'b1; bus.p2s_enable = 1'($urandom_range(0, 1));
      tick();
      rx_word = '0; rx_cnt = 0;
      for (int c = 0; c < 400 && m_busy; c++) begin
        bus.p2s_enable = ($urandom_range(0, 3) != 0);
        bus.p2s_load   = ($urandom_range(0, 7) == 0);
        bus.p2s_din    = $urandom;
        tick();
      end
      bus.p2s_load = 1'b0;
      check("p2s_rand_word", rx_word, din_saved);
      check("p2s_rand_busy", bus.p2s_busy, 1'b0);
      tick();
    end

    // asynchronous reset in the middle of a shift
    bus.p2s_din = $urandom; bus.p2s_load = 1'b1; tick();
    bus.p2s_load = 1'b0; bus.p2s_enable = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",    bus.p2s_busy,    1'b0);
    check("mid_rst_valid",   bus.p2s_valid,   1'b0);
    check("mid_rst_ser_out", bus.p2s_ser_out, 1'b0);
    check("mid_rst_done",    bus.ld_done,     1'b0);
    check("mid_rst_addr",    bus.mem_addr,    '0);
    model_reset();
    bus.p2s_enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.p2s_enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
